// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, BCD limits and BCD increment helper for the clock core
package clock_pkg;
    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: two-digit packed BCD counter wrapping at MAX, with combinational carry-out
module bcd_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);
    logic [7:0] r_value;
    assign value = r_value;
    assign carry = inc && (r_value == MAX);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_value <= 8'h00;
        else if (clr)
            r_value <= 8'h00;
        else if (inc)
            r_value <= carry ? 8'h00 : bcd_inc(r_value);
    end
endmodule

// File: rtl/clock_counter.sv
// clock_counter: 1 Hz prescaler, 24-hour BCD timekeeping and key-driven hour/minute set mode
module clock_counter
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       Sec_Tick,
    output logic       Setting
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          r_key_mode_d;
    logic          r_key_inc_d;
    logic          r_sec_tick;
    logic          r_setting;
    logic          w_mode_ev;
    logic          w_inc_ev;
    logic          w_tick;
    logic          w_sec_clr;
    logic          w_sec_carry;
    logic          w_min_inc;
    logic          w_min_carry;
    logic          w_hour_inc;
    // mode has priority: an inc arriving on the same edge is dropped
    assign w_mode_ev = key_mode & ~r_key_mode_d;
    assign w_inc_ev  = key_inc & ~r_key_inc_d & ~w_mode_ev;
    always_comb begin
        w_state_next = !w_mode_ev ? r_state :
                       (r_state == RUN)      ? SET_HOUR :
                       (r_state == SET_HOUR) ? SET_MIN : RUN;
        w_tick       = (r_state == RUN) && !w_mode_ev && (r_presc == PRE_MAX);
        w_presc_next = (r_state != RUN || w_mode_ev || w_tick) ? '0 : r_presc + PW'(1);
        w_sec_clr    = (r_state == RUN) && w_mode_ev;
        w_min_inc    = w_sec_carry || ((r_state == SET_MIN) && w_inc_ev);
        w_hour_inc   = (w_sec_carry && w_min_carry) || ((r_state == SET_HOUR) && w_inc_ev);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_key_mode_d <= 1'b0;
            r_key_inc_d  <= 1'b0;
            r_sec_tick   <= 1'b0;
            r_setting    <= 1'b0;
        end else begin
            r_presc      <= w_presc_next;
            r_key_mode_d <= key_mode;
            r_key_inc_d  <= key_inc;
            r_sec_tick   <= w_tick;
            r_setting    <= (w_state_next != RUN);
        end
    end
    bcd_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .inc(w_tick), .clr(w_sec_clr),
        .value(Second), .carry(w_sec_carry)
    );
    bcd_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .inc(w_min_inc), .clr(1'b0),
        .value(Minute), .carry(w_min_carry)
    );
    // hours wrap at midnight with nothing above them, so their carry is left open
    bcd_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .inc(w_hour_inc), .clr(1'b0),
        .value(Hour), .carry()
    );
    assign Sec_Tick = r_sec_tick;
    assign Setting  = r_setting;
endmodule

// File: tb/tb_clock_counter.sv
// tb_clock_counter: random and directed stimulus checked each cycle against an integer time-of-day model
module tb_clock_counter;
    localparam int DIV = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [7:0] Hour, Minute, Second;
    logic       Sec_Tick, Setting;
    int         n_cmp = 0;
    int         n_err = 0;
    int         m_h, m_m, m_s, m_mode, m_cnt;
    bit         m_tick, m_pkm, m_pki;

    clock_counter #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
        .Hour(Hour), .Minute(Minute), .Second(Second),
        .Sec_Tick(Sec_Tick), .Setting(Setting)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_cnt = 0;
        m_tick = 0; m_pkm = 0; m_pki = 0;
    endtask

    // mode 0 = running, 1 = setting hours, 2 = setting minutes
    task automatic model_step(input bit km, input bit ki);
        bit mev, iev;
        int t;
        mev = km && !m_pkm;
        iev = ki && !m_pki && !mev;
        m_pkm = km;
        m_pki = ki;
        m_tick = 0;
        if (m_mode == 0) begin
            if (mev) begin
                m_mode = 1; m_s = 0; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt = 0;
                    m_tick = 1;
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                end
            end
        end else if (m_mode == 1) begin
            m_cnt = 0;
            if (mev) m_mode = 2;
            else if (iev) m_h = (m_h + 1) % 24;
        end else begin
            m_cnt = 0;
            if (mev) m_mode = 0;
            else if (iev) m_m = (m_m + 1) % 60;
        end
    endtask

    task automatic check_all();
        chk("hour", Hour, to_bcd(m_h));
        chk("minute", Minute, to_bcd(m_m));
        chk("second", Second, to_bcd(m_s));
        chk("sec_tick", {7'b0, Sec_Tick}, {7'b0, m_tick});
        chk("setting", {7'b0, Setting}, {7'b0, m_mode != 0});
    endtask

    task automatic cycle(input bit km, input bit ki);
        key_mode = km;
        key_inc = ki;
        @(posedge clk);
        model_step(km, ki);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_mode = 1'b0;
        key_inc = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic press_mode();
        cycle(1, 0);
        cycle(0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1);
            cycle(0, 0);
        end
    endtask

    initial begin
        do_reset();
        chk("rst_hour", Hour, 8'h00);
        chk("rst_setting", {7'b0, Setting}, 8'h00);
        repeat (4) cycle(0, 0);
        chk("first_sec", Second, 8'h01);
        chk("first_tick", {7'b0, Sec_Tick}, 8'h01);
        repeat (36) cycle(0, 0);
        chk("ten_sec", Second, 8'h10);

        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        repeat (231) cycle(0, 0);
        chk("pre_h", Hour, 8'h23);
        chk("pre_m", Minute, 8'h59);
        chk("pre_s", Second, 8'h58);
        repeat (4) cycle(0, 0);
        chk("s59", Second, 8'h59);
        repeat (4) cycle(0, 0);
        chk("wrap_h", Hour, 8'h00);
        chk("wrap_m", Minute, 8'h00);
        chk("wrap_s", Second, 8'h00);
        chk("wrap_tick", {7'b0, Sec_Tick}, 8'h01);

        do_reset();
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(34);
        press_mode();
        repeat (223) cycle(0, 0);
        chk("t_s56", Second, 8'h56);
        press_mode();
        chk("set_on", {7'b0, Setting}, 8'h01);
        chk("set_sec_clr", Second, 8'h00);
        repeat (100) cycle(0, 0);
        chk("frozen_h", Hour, 8'h12);
        chk("frozen_m", Minute, 8'h34);
        press_inc(2);
        chk("hour14", Hour, 8'h14);
        press_mode();
        press_inc(24);
        chk("min58", Minute, 8'h58);
        press_inc(1);
        chk("min59", Minute, 8'h59);
        press_inc(1);
        chk("min00", Minute, 8'h00);
        press_inc(1);
        chk("min01", Minute, 8'h01);
        chk("no_hour_carry", Hour, 8'h14);
        cycle(1, 0);
        chk("run_again", {7'b0, Setting}, 8'h00);
        repeat (3) cycle(0, 0);
        chk("no_early_tick", {7'b0, Sec_Tick}, 8'h00);
        cycle(0, 0);
        chk("tick_after_exit", {7'b0, Sec_Tick}, 8'h01);

        press_mode();
        repeat (10) cycle(0, 1);
        cycle(0, 0);
        chk("held_inc", Hour, 8'h15);
        cycle(1, 1);
        chk("both_hour", Hour, 8'h15);
        chk("both_min", Minute, 8'h01);
        cycle(0, 0);
        press_inc(1);
        chk("in_set_min", Minute, 8'h02);

        do_reset();
        press_mode();
        press_inc(7);
        press_mode();
        press_inc(45);
        chk("pre_rst_h", Hour, 8'h07);
        chk("pre_rst_m", Minute, 8'h45);
        #2 rst = 1'b1;
        #1;
        chk("arst_h", Hour, 8'h00);
        chk("arst_m", Minute, 8'h00);
        chk("arst_s", Second, 8'h00);
        chk("arst_setting", {7'b0, Setting}, 8'h00);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
